// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// ALU results go straight through; load results wait in a small FIFO.
module wb_arbiter #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            rf_we,
   output logic [4:0]      rf_rw,
   output logic [XLEN-1:0] rf_w,
   output logic [31:0]     pend_mask,
   output logic [31:0]     wb_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [4:0]      fifo_rd_r   [DEPTH];
   logic [XLEN-1:0] fifo_data_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;

   logic            rf_we_r;
   logic [4:0]      rf_rw_r;
   logic [XLEN-1:0] rf_w_r;
   logic [31:0]     wb_count_r;

   logic            full_s;
   logic            empty_s;
   logic            fifo_grant_s;
   logic            push_s;
   logic            pop_s;
   logic            alu_fire_s;
   logic            selected_s;
   logic            wr_next_s;
   logic [4:0]      sel_rd_s;
   logic [XLEN-1:0] sel_data_s;
   logic [31:0]     pend_s;
   logic [AW-1:0]   off_s;

   assign full_s       = (count_r == DEPTH_C);
   assign empty_s      = (count_r == {CW{1'b0}});
   // A full FIFO overrides the ALU so loads cannot starve.
   assign fifo_grant_s = !empty_s && (!alu_valid || full_s);
   assign alu_ready    = !rst && !fifo_grant_s;
   assign mem_ready    = !rst && !full_s;
   assign push_s       = mem_valid && mem_ready;
   assign pop_s        = fifo_grant_s && !rst;
   assign alu_fire_s   = alu_valid && alu_ready;
   assign selected_s   = pop_s || alu_fire_s;
   assign wr_next_s    = selected_s && (sel_rd_s != 5'd0);

   // Source select: FIFO head when granted, otherwise the ALU.
   always_comb begin
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
      if (fifo_grant_s) begin
         sel_rd_s   = fifo_rd_r[rd_ptr_r];
         sel_data_s = fifo_data_r[rd_ptr_r];
      end else begin
         sel_rd_s   = alu_rd;
         sel_data_s = alu_data;
      end
   end

   // FIFO storage; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_rd_r[wr_ptr_r]   <= mem_rd;
         fifo_data_r[wr_ptr_r] <= mem_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Registered write port and write-back event counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_r    <= 1'b0;
         rf_rw_r    <= 5'd0;
         rf_w_r     <= {XLEN{1'b0}};
         wb_count_r <= 32'd0;
      end else begin
         rf_we_r <= wr_next_s;
         if (wr_next_s) begin
            rf_rw_r    <= sel_rd_s;
            rf_w_r     <= sel_data_s;
            wb_count_r <= wb_count_r + 32'd1;
         end
      end
   end

   // Pending-write mask: live FIFO entries plus the write in the output stage.
   always_comb begin
      pend_s = 32'd0;
      off_s  = {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         off_s = AW'(i) - rd_ptr_r;
         if ({1'b0, off_s} < count_r) begin
            pend_s[fifo_rd_r[i]] = 1'b1;
         end else begin
            pend_s = pend_s;
         end
      end
      if (rf_we_r) begin
         pend_s[rf_rw_r] = 1'b1;
      end else begin
         pend_s = pend_s;
      end
      pend_s[0] = 1'b0;
   end

   assign rf_we     = rf_we_r;
   assign rf_rw     = rf_rw_r;
   assign rf_w      = rf_w_r;
   assign wb_count  = wb_count_r;
   assign pend_mask = pend_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;

   localparam int XLEN  = 64;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            alu_valid = 1'b0;
   logic            alu_ready;
   logic [4:0]      alu_rd = 5'd0;
   logic [XLEN-1:0] alu_data = 64'd0;
   logic            mem_valid = 1'b0;
   logic            mem_ready;
   logic [4:0]      mem_rd = 5'd0;
   logic [XLEN-1:0] mem_data = 64'd0;
   logic            rf_we;
   logic [4:0]      rf_rw;
   logic [XLEN-1:0] rf_w;
   logic [31:0]     pend_mask;
   logic [31:0]     wb_count;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .rf_we(rf_we), .rf_rw(rf_rw), .rf_w(rf_w), .pend_mask(pend_mask), .wb_count(wb_count)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   ent_t        q[$];
   bit          exp_we  = 1'b0;
   logic [4:0]  exp_rw  = 5'd0;
   logic [63:0] exp_w   = 64'd0;
   logic [31:0] exp_cnt = 32'd0;
   bit          m_ar = 1'b0;
   bit          m_mr = 1'b0;
   logic        obs_ar, obs_mr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] m;
      m = 32'd0;
      foreach (q[i]) m[q[i].rd] = 1'b1;
      if (exp_we) m[exp_rw] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   // One clock cycle: drive, check handshakes, advance the model, check outputs.
   task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [63:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [63:0] md);
      ent_t e;
      bit fgrant, sel, full, empty;
      logic [4:0]  srd;
      logic [63:0] sd;
      fgrant = 1'b0; sel = 1'b0; srd = 5'd0; sd = 64'd0;
      @(negedge clk);
      rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      #1;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (r) begin
         m_ar = 1'b0; m_mr = 1'b0;
      end else begin
         fgrant = !empty && (!av || full);
         m_ar = !fgrant;
         m_mr = !full;
      end
      obs_ar = alu_ready;
      obs_mr = mem_ready;
      chk("alu_ready", {63'd0, alu_ready}, {63'd0, m_ar});
      chk("mem_ready", {63'd0, mem_ready}, {63'd0, m_mr});
      if (r) begin
         q.delete();
         exp_we = 1'b0; exp_rw = 5'd0; exp_w = 64'd0; exp_cnt = 32'd0;
      end else begin
         if (fgrant) begin
            e = q.pop_front();
            sel = 1'b1; srd = e.rd; sd = e.data;
         end else if (av) begin
            sel = 1'b1; srd = ard; sd = ad;
         end
         if (mv && m_mr) begin
            e.rd = mrd; e.data = md;
            q.push_back(e);
         end
         exp_we = sel && (srd != 5'd0);
         if (exp_we) begin
            exp_rw = srd; exp_w = sd; exp_cnt = exp_cnt + 32'd1;
         end
      end
      @(posedge clk);
      #1;
      chk("rf_we",     {63'd0, rf_we},     {63'd0, exp_we});
      chk("rf_rw",     {59'd0, rf_rw},     {59'd0, exp_rw});
      chk("rf_w",      rf_w,               exp_w);
      chk("wb_count",  {32'd0, wb_count},  {32'd0, exp_cnt});
      chk("pend_mask", {32'd0, pend_mask}, {32'd0, model_pend()});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
   endtask

   initial begin
      bit          cav, cmv;
      logic [4:0]  card, cmrd;
      logic [63:0] cad, cmd;
      bit          seen_stale;

      // Reset then idle
      step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      idle(1);
      chk("lit_reset_we",    {63'd0, rf_we},    64'd0);
      chk("lit_reset_pend",  {32'd0, pend_mask}, 64'd0);
      chk("lit_reset_cnt",   {32'd0, wb_count}, 64'd0);
      chk("lit_reset_ar",    {63'd0, obs_ar},   64'd1);
      chk("lit_reset_mr",    {63'd0, obs_mr},   64'd1);

      // x0 write is consumed without a register-file write
      step(1'b0, 1'b1, 5'd0, 64'h0000_0000_0000_FFFF, 1'b0, 5'd0, 64'd0);
      chk("lit_x0_ar",  {63'd0, obs_ar},   64'd1);
      chk("lit_x0_we",  {63'd0, rf_we},    64'd0);
      chk("lit_x0_cnt", {32'd0, wb_count}, 64'd0);

      // Single ALU write
      step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 64'd0);
      chk("lit_alu_we",   {63'd0, rf_we},     64'd1);
      chk("lit_alu_rw",   {59'd0, rf_rw},     64'd5);
      chk("lit_alu_w",    rf_w,               64'hDEAD_BEEF_0000_0001);
      chk("lit_alu_pend", {32'd0, pend_mask}, 64'h0000_0000_0000_0020);
      chk("lit_alu_cnt",  {32'd0, wb_count},  64'd1);
      idle(1);

      // Starvation: ALU busy while four loads fill the FIFO
      for (int k = 1; k <= 4; k++)
         step(1'b0, 1'b1, 5'd10, 64'h100 + 64'(k), 1'b1, 5'(k), 64'hA0 + 64'(k));
      chk("lit_full_pend", {32'd0, pend_mask}, 64'h0000_0000_0000_041E);
      step(1'b0, 1'b1, 5'd10, 64'h0000_0000_0000_0105, 1'b0, 5'd0, 64'd0);
      chk("lit_full_mr",   {63'd0, obs_mr},    64'd0);
      chk("lit_full_ar",   {63'd0, obs_ar},    64'd0);
      chk("lit_drain_rw1", {59'd0, rf_rw},     64'd1);
      chk("lit_drain_w1",  rf_w,               64'h0000_0000_0000_00A1);
      chk("lit_drain_p1",  {32'd0, pend_mask}, 64'h0000_0000_0000_001E);
      step(1'b0, 1'b1, 5'd11, 64'h0000_0000_0000_0106, 1'b0, 5'd0, 64'd0);
      chk("lit_alu_back",  {59'd0, rf_rw},     64'd11);
      for (int k = 2; k <= 4; k++) begin
         idle(1);
         chk("lit_drain_rw", {59'd0, rf_rw}, 64'(k));
      end
      chk("lit_drained_pend", {32'd0, pend_mask}, 64'h0000_0000_0000_0010);
      idle(1);

      // Reset with three loads queued
      for (int k = 7; k <= 9; k++)
         step(1'b0, 1'b1, 5'd0, 64'd0, 1'b1, 5'(k), 64'hC0 + 64'(k));
      chk("lit_q3_pend", {32'd0, pend_mask}, 64'h0000_0000_0000_0380);
      step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      chk("lit_mrst_mr",   {63'd0, obs_mr},    64'd0);
      chk("lit_mrst_we",   {63'd0, rf_we},     64'd0);
      chk("lit_mrst_pend", {32'd0, pend_mask}, 64'd0);
      seen_stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         if (rf_we) seen_stale = 1'b1;
      end
      chk("lit_no_stale", {63'd0, seen_stale}, 64'd0);

      // Randomized traffic; producers hold offers until accepted
      cav = 1'b0; cmv = 1'b0; card = 5'd0; cmrd = 5'd0; cad = 64'd0; cmd = 64'd0;
      for (int i = 0; i < 200; i++) begin
         if (!(cav && !m_ar)) begin
            cav  = ($urandom_range(0, 9) < 6);
            card = 5'($urandom_range(0, 31));
            cad  = {$urandom, $urandom};
         end
         if (!(cmv && !m_mr)) begin
            cmv  = ($urandom_range(0, 9) < 5);
            cmrd = 5'($urandom_range(0, 31));
            cmd  = {$urandom, $urandom};
         end
         step(1'b0, cav, card, cad, cmv, cmrd, cmd);
      end
      idle(DEPTH + 2);
      chk("final_empty", {32'd0, pend_mask}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
